cache_tagarray_ctrl: RTL and testbench

- Sequencing and sharing controller for the 2-way cache tag array SRAM (512 sets, 38-bit entries, 1-cycle registered read).
- Arbitrates a lookup requester (pipeline read plus tag compare) against an update requester (refill/dirty writes).
- Runs an invalidate-all sweep after reset and on flush request.
- Drives the SRAM's ce/we/waddr/raddr/din/wmask and returns hit/way/dirty one cycle after a lookup is accepted.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_tag_cmp.sv | 27 ++
 rtl/cache_tagarray_ctrl.sv | 121 ++++++++++++
 tb/tb_cache_tagarray_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache tag array: entry field layout, derived widths
// and the controller state encoding.
package cache_pkg;

  localparam int ADDR_WIDTH = 9;
  localparam int TAG_WIDTH  = 17;
  localparam int WAY_WIDTH  = TAG_WIDTH + 2;
  localparam int DATA_WIDTH = 2 * WAY_WIDTH;
  localparam int NUM_SETS   = 1 << ADDR_WIDTH;

  // Per-way entry layout: {valid, dirty, tag}
  localparam int VALID_BIT = WAY_WIDTH - 1;
  localparam int DIRTY_BIT = WAY_WIDTH - 2;

  typedef enum logic {
    FLUSH = 1'b0,
    IDLE  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/cache_tag_cmp.sv
// Combinational 2-way valid/tag compare; way0 wins when both ways hit.
module cache_tag_cmp
  import cache_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] entry,
  input  logic [TAG_WIDTH-1:0]  tag,
  output logic                  hit,
  output logic                  way,
  output logic                  dirty
);

  logic [WAY_WIDTH-1:0] way0;
  logic [WAY_WIDTH-1:0] way1;
  logic                 hit0;
  logic                 hit1;

  always_comb begin
    way0  = entry[WAY_WIDTH-1:0];
    way1  = entry[DATA_WIDTH-1:WAY_WIDTH];
    hit0  = way0[VALID_BIT] && (way0[TAG_WIDTH-1:0] == tag);
    hit1  = way1[VALID_BIT] && (way1[TAG_WIDTH-1:0] == tag);
    hit   = hit0 || hit1;
    way   = !hit0 && hit1;
    dirty = hit0 ? way0[DIRTY_BIT] : (hit1 ? way1[DIRTY_BIT] : 1'b0);
  end

endmodule

// File: rtl/cache_tagarray_ctrl.sv
// Tag array SRAM sequencer: invalidate-all sweep, lookup/update arbitration and
// registered-read hit response.
module cache_tagarray_ctrl
  import cache_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush_req,
  output logic                  flush_busy,
  input  logic                  lkp_valid,
  output logic                  lkp_ready,
  input  logic [ADDR_WIDTH-1:0] lkp_set,
  input  logic [TAG_WIDTH-1:0]  lkp_tag,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic                  rsp_way,
  output logic                  rsp_dirty,
  output logic [DATA_WIDTH-1:0] rsp_entry,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [ADDR_WIDTH-1:0] upd_set,
  input  logic                  upd_way,
  input  logic [WAY_WIDTH-1:0]  upd_entry,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic [DATA_WIDTH-1:0] sram_wmask,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rsp_pend_q, rsp_pend_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;

  logic cmp_hit;
  logic cmp_way;
  logic cmp_dirty;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= FLUSH;
      cnt_q      <= '0;
      rsp_pend_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_pend_q <= rsp_pend_d;
      tag_q      <= tag_d;
    end
  end

  // SRAM strobes are held off while reset is asserted even though the state is FLUSH
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_pend_d = 1'b0;
    tag_d      = tag_q;
    flush_busy = 1'b0;
    lkp_ready  = 1'b0;
    upd_ready  = 1'b0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_waddr = upd_set;
    sram_raddr = lkp_set;
    sram_din   = '0;
    sram_wmask = '0;
    case (state_q)
      FLUSH: begin
        flush_busy = 1'b1;
        sram_ce    = reset_n;
        sram_we    = reset_n;
        sram_waddr = cnt_q;
        sram_wmask = '1;
        cnt_d      = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        upd_ready = 1'b1;
        lkp_ready = !(upd_valid && (upd_set == lkp_set));
        if (upd_valid) begin
          sram_ce    = reset_n;
          sram_we    = reset_n;
          sram_din   = {upd_entry, upd_entry};
          sram_wmask = upd_way ? {{WAY_WIDTH{1'b1}}, {WAY_WIDTH{1'b0}}}
                               : {{WAY_WIDTH{1'b0}}, {WAY_WIDTH{1'b1}}};
        end
        if (lkp_valid && lkp_ready) begin
          sram_ce    = reset_n;
          rsp_pend_d = 1'b1;
          tag_d      = lkp_tag;
        end
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  cache_tag_cmp u_cmp (
    .entry (sram_dout),
    .tag   (tag_q),
    .hit   (cmp_hit),
    .way   (cmp_way),
    .dirty (cmp_dirty)
  );

  assign rsp_valid = rsp_pend_q;
  assign rsp_hit   = rsp_pend_q && cmp_hit;
  assign rsp_way   = rsp_pend_q && cmp_way;
  assign rsp_dirty = rsp_pend_q && cmp_dirty;
  assign rsp_entry = sram_dout;

endmodule

// File: tb/tb_cache_tagarray_ctrl.sv
// Self-checking bench for cache_tagarray_ctrl: behavioural SRAM, per-way
// reference model, directed steps followed by randomized traffic.
module tb_cache_tagarray_ctrl;
  import cache_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  flush_req = 1'b0;
  logic                  flush_busy;
  logic                  lkp_valid = 1'b0;
  logic                  lkp_ready;
  logic [ADDR_WIDTH-1:0] lkp_set = '0;
  logic [TAG_WIDTH-1:0]  lkp_tag = '0;
  logic                  rsp_valid, rsp_hit, rsp_way, rsp_dirty;
  logic [DATA_WIDTH-1:0] rsp_entry;
  logic                  upd_valid = 1'b0;
  logic                  upd_ready;
  logic [ADDR_WIDTH-1:0] upd_set = '0;
  logic                  upd_way = 1'b0;
  logic [WAY_WIDTH-1:0]  upd_entry = '0;
  logic                  sram_ce, sram_we;
  logic [ADDR_WIDTH-1:0] sram_waddr, sram_raddr;
  logic [DATA_WIDTH-1:0] sram_din, sram_wmask, sram_dout;

  always #5 clock = ~clock;

  cache_tagarray_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .lkp_valid  (lkp_valid),
    .lkp_ready  (lkp_ready),
    .lkp_set    (lkp_set),
    .lkp_tag    (lkp_tag),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_way    (rsp_way),
    .rsp_dirty  (rsp_dirty),
    .rsp_entry  (rsp_entry),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_set    (upd_set),
    .upd_way    (upd_way),
    .upd_entry  (upd_entry),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_waddr (sram_waddr),
    .sram_raddr (sram_raddr),
    .sram_din   (sram_din),
    .sram_wmask (sram_wmask),
    .sram_dout  (sram_dout)
  );

  // Bit-masked write, registered read; contents start as garbage so the sweep matters
  logic [DATA_WIDTH-1:0] mem [NUM_SETS];
  logic                  scramble = 1'b1;

  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < NUM_SETS; i++) mem[i] <= DATA_WIDTH'({$urandom(), $urandom()});
    end else if (sram_ce && sram_we) begin
      mem[sram_waddr] <= (mem[sram_waddr] & ~sram_wmask) | (sram_din & sram_wmask);
    end
    if (sram_ce) sram_dout <= mem[sram_raddr];
  end

  logic                 ref_valid [NUM_SETS][2];
  logic                 ref_dirty [NUM_SETS][2];
  logic [TAG_WIDTH-1:0] ref_tag   [NUM_SETS][2];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic                         chain = 1'b0;
  logic                         prev_acc = 1'b0;
  logic [DATA_WIDTH+2:0]        prev_exp = '0;

  task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic void clearModel();
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int k = 0; k < 2; k++) begin
        ref_valid[s][k] = 1'b0;
        ref_dirty[s][k] = 1'b0;
        ref_tag[s][k]   = '0;
      end
    end
  endfunction

  task automatic modelLookup(input logic [ADDR_WIDTH-1:0] s, input logic [TAG_WIDTH-1:0] t,
                             output logic [DATA_WIDTH+2:0] exp);
    logic h, w, d;
    h = 1'b0; w = 1'b0; d = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (!h && ref_valid[s][k] && ref_tag[s][k] == t) begin
        h = 1'b1;
        w = (k == 1);
        d = ref_dirty[s][k];
      end
    end
    exp = {h, w, d, ref_valid[s][1], ref_dirty[s][1], ref_tag[s][1],
           ref_valid[s][0], ref_dirty[s][0], ref_tag[s][0]};
  endtask

  task automatic applyStimulus(input logic uv, input logic [ADDR_WIDTH-1:0] us, input logic uw,
                               input logic [WAY_WIDTH-1:0] ue, input logic lv,
                               input logic [ADDR_WIDTH-1:0] ls, input logic [TAG_WIDTH-1:0] lt,
                               input logic fr);
    logic                  exp_lr, acc;
    logic [DATA_WIDTH-1:0] exp_mask;
    logic [DATA_WIDTH+2:0] exp_rsp;
    @(negedge clock);
    upd_valid = uv; upd_set = us; upd_way = uw; upd_entry = ue;
    lkp_valid = lv; lkp_set = ls; lkp_tag = lt; flush_req = fr;
    #1;
    if (chain) begin
      if (prev_acc)
        checkOutput("rsp_hold", 128'({rsp_valid, rsp_hit, rsp_way, rsp_dirty, rsp_entry}),
                    128'({1'b1, prev_exp}));
      else
        checkOutput("rsp_quiet", 128'(rsp_valid), 128'(1'b0));
    end
    exp_lr = !(uv && us == ls);
    acc    = lv && exp_lr;
    checkOutput("upd_ready", 128'(upd_ready), 128'(1'b1));
    checkOutput("lkp_ready", 128'(lkp_ready), 128'(exp_lr));
    checkOutput("sram_ce_we", 128'({sram_ce, sram_we}), 128'({uv || acc, uv}));
    if (uv) begin
      exp_mask = uw ? {{WAY_WIDTH{1'b1}}, {WAY_WIDTH{1'b0}}} : {{WAY_WIDTH{1'b0}}, {WAY_WIDTH{1'b1}}};
      checkOutput("sram_write", 128'({sram_waddr, sram_din, sram_wmask}), 128'({us, ue, ue, exp_mask}));
    end
    if (acc) checkOutput("sram_raddr", 128'(sram_raddr), 128'(ls));
    modelLookup(ls, lt, exp_rsp);
    @(posedge clock);
    if (uv) begin
      ref_valid[us][uw] = ue[VALID_BIT];
      ref_dirty[us][uw] = ue[DIRTY_BIT];
      ref_tag[us][uw]   = ue[TAG_WIDTH-1:0];
    end
    if (fr) clearModel();
    #1;
    checkOutput("rsp_valid", 128'(rsp_valid), 128'(acc));
    if (acc)
      checkOutput("rsp", 128'({rsp_hit, rsp_way, rsp_dirty, rsp_entry}), 128'(exp_rsp));
    else
      checkOutput("rsp_zero", 128'({rsp_hit, rsp_way, rsp_dirty}), 128'(3'b000));
    upd_valid = 1'b0; lkp_valid = 1'b0; flush_req = 1'b0;
    prev_acc = acc;
    prev_exp = exp_rsp;
    chain = !fr;
  endtask

  // Caller is positioned just after a negedge with the sweep about to write set 'start'
  task automatic checkSweep(input int start, input int cycles, input logic full);
    chain = 1'b0;
    for (int i = start; i < start + cycles; i++) begin
      #1;
      checkOutput("sweep", 128'({flush_busy, sram_ce, sram_we, sram_waddr, sram_din, sram_wmask,
                                 lkp_ready, upd_ready}),
                  128'({3'b111, ADDR_WIDTH'(i), {DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b1}}, 2'b00}));
      @(negedge clock);
    end
    if (full) begin
      #1;
      checkOutput("sweep_done", 128'({flush_busy, lkp_ready, upd_ready, sram_ce, sram_we}),
                  128'(5'b01100));
      clearModel();
    end
  endtask

  task automatic checkResetState();
    checkOutput("reset_state", 128'({rsp_valid, rsp_hit, rsp_way, rsp_dirty, flush_busy,
                                     lkp_ready, upd_ready, sram_we, sram_ce}),
                128'(9'b0000_1_0000));
  endtask

  localparam logic [TAG_WIDTH-1:0] TAG_POOL [4] = '{17'h1ABCD, 17'h00001, 17'h00F0F, 17'h00000};

  initial begin
    logic [TAG_WIDTH-1:0] t;
    clearModel();
    reset_n = 1'b0;
    @(posedge clock);
    #1 scramble = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checkResetState();
    @(negedge clock);
    reset_n = 1'b1;
    checkSweep(0, NUM_SETS, 1'b1);

    applyStimulus(1, 9'd5, 1, {1'b1, 1'b1, 17'h1ABCD}, 0, 9'd0, 17'h0, 0);
    applyStimulus(0, 9'd0, 0, '0, 1, 9'd5, 17'h1ABCD, 0);
    applyStimulus(0, 9'd0, 0, '0, 1, 9'd5, 17'h00001, 0);
    applyStimulus(1, 9'd5, 0, {1'b1, 1'b0, 17'h00001}, 0, 9'd0, 17'h0, 0);
    applyStimulus(1, 9'd7, 0, {1'b1, 1'b1, 17'h12345}, 0, 9'd0, 17'h0, 0);
    applyStimulus(0, 9'd0, 0, '0, 1, 9'd5, 17'h00001, 0);
    applyStimulus(1, 9'd5, 0, {1'b1, 1'b0, 17'h1ABCD}, 0, 9'd0, 17'h0, 0);
    applyStimulus(0, 9'd0, 0, '0, 1, 9'd5, 17'h1ABCD, 0);
    applyStimulus(1, 9'd9, 0, {1'b1, 1'b0, 17'h0AAAA}, 1, 9'd9, 17'h0AAAA, 0);
    applyStimulus(0, 9'd0, 0, '0, 1, 9'd9, 17'h0AAAA, 0);
    applyStimulus(1, 9'd10, 1, {1'b1, 1'b1, 17'h0BBBB}, 1, 9'd9, 17'h0AAAA, 0);
    applyStimulus(0, 9'd0, 0, '0, 1, 9'd10, 17'h0BBBB, 0);
    applyStimulus(0, 9'd0, 0, '0, 0, 9'd0, 17'h0, 0);

    applyStimulus(0, 9'd0, 0, '0, 1, 9'd5, 17'h1ABCD, 1);
    @(negedge clock);
    checkSweep(0, 100, 1'b0);
    flush_req = 1'b1;
    checkSweep(100, 5, 1'b0);
    flush_req = 1'b0;
    checkSweep(105, NUM_SETS - 105, 1'b1);
    applyStimulus(0, 9'd0, 0, '0, 1, 9'd5, 17'h1ABCD, 0);

    for (int n = 0; n < 400; n++) begin
      t = TAG_POOL[$urandom_range(0, 3)];
      applyStimulus(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     TAG_POOL[$urandom_range(0, 3)]},
                    1'($urandom_range(0, 4) != 0), 9'($urandom_range(0, 15)), t, 1'b0);
    end

    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    checkSweep(0, 200, 1'b0);
    reset_n = 1'b0;
    #1;
    checkResetState();
    @(negedge clock);
    reset_n = 1'b1;
    checkSweep(0, NUM_SETS, 1'b1);

    applyStimulus(1, 9'd5, 0, {1'b1, 1'b0, 17'h00F0F}, 0, 9'd0, 17'h0, 0);
    @(negedge clock);
    chain = 1'b0;
    lkp_valid = 1'b1; lkp_set = 9'd5; lkp_tag = 17'h00F0F;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("reset_drops_rsp", 128'(rsp_valid), 128'(1'b0));
    lkp_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    checkSweep(0, NUM_SETS, 1'b1);
    applyStimulus(0, 9'd0, 0, '0, 1, 9'd5, 17'h00F0F, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
